// File: rtl/tmr_scrub_if.sv
// Shared bank port between the scrub controller and a TMR register bank.
// The controller is the master; the bank (with its arbiter) is the slave.
interface tmr_scrub_if #(
   parameter int unsigned AW = 4,
   parameter int unsigned DW = 8
);
   logic          bank_req;
   logic          bank_gnt;
   logic [AW-1:0] addr;
   logic          rd_en;
   logic [DW-1:0] rdataA;
   logic [DW-1:0] rdataB;
   logic [DW-1:0] rdataC;
   logic          wr_en;
   logic [DW-1:0] wdata;

   modport master (
      output bank_req, addr, rd_en, wr_en, wdata,
      input  bank_gnt, rdataA, rdataB, rdataC
   );

   modport slave (
      input  bank_req, addr, rd_en, wr_en, wdata,
      output bank_gnt, rdataA, rdataB, rdataC
   );
endinterface

// File: rtl/tmr_scrub_ctrl.sv
// Scrubber for triplicated register banks: walks every word, votes the A/B/C
// copies bitwise and writes the majority back when any copy disagrees.
module tmr_scrub_ctrl #(
   parameter int unsigned NREGS    = 16,
   parameter int unsigned AW       = 4,
   parameter int unsigned DW       = 8,
   parameter int unsigned INTERVAL = 1024,
   parameter int unsigned CNTW     = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            scrub_req,
   tmr_scrub_if.master     bank,
   output logic            busy,
   output logic            done,
   output logic [2:0]      err_lane,
   output logic            err_flag,
   output logic [CNTW-1:0] err_cnt,
   input  logic            err_clr
);

   localparam int unsigned     TW           = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
   localparam logic [TW-1:0]   TIMER_RELOAD = TW'(INTERVAL - 1);
   localparam logic [AW-1:0]   LAST_ADDR    = AW'(NREGS - 1);
   localparam logic [CNTW-1:0] CNT_MAX      = '1;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] REQ   = 3'd1;
   localparam logic [2:0] READ  = 3'd2;
   localparam logic [2:0] WAIT  = 3'd3;
   localparam logic [2:0] VOTE  = 3'd4;
   localparam logic [2:0] WRITE = 3'd5;
   localparam logic [2:0] NEXT  = 3'd6;

   logic [2:0]    state;
   logic [2:0]    nextState;
   logic [TW-1:0] timer;
   logic [AW-1:0] wordAddr;
   logic          active;
   logic [DW-1:0] capA;
   logic [DW-1:0] capB;
   logic [DW-1:0] capC;
   logic [DW-1:0] vote;
   logic [DW-1:0] wdataReg;
   logic [2:0]    laneMis;
   logic          mismatch;

   assign bank.bank_req = active;
   assign busy          = active;
   assign bank.addr     = wordAddr;
   assign bank.wdata    = wdataReg;

   // Bitwise majority of the captured copies and per-lane disagreement.
   assign vote     = (capA & capB) | (capB & capC) | (capA & capC);
   assign laneMis  = {capC != vote, capB != vote, capA != vote};
   assign mismatch = |laneMis;

   // Strobes follow the grant combinationally so a dropped grant never sees one.
   always_comb begin : fsmComb
      nextState  = state;
      bank.rd_en = 1'b0;
      bank.wr_en = 1'b0;
      case (state)
         IDLE: begin
            if (timer == '0 || scrub_req) nextState = REQ;
         end
         REQ: begin
            if (bank.bank_gnt) nextState = READ;
         end
         READ: begin
            bank.rd_en = bank.bank_gnt;
            if (bank.bank_gnt) nextState = WAIT;
         end
         WAIT: begin
            nextState = VOTE;
         end
         VOTE: begin
            nextState = mismatch ? WRITE : NEXT;
         end
         WRITE: begin
            bank.wr_en = bank.bank_gnt;
            if (bank.bank_gnt) nextState = NEXT;
         end
         NEXT: begin
            nextState = (wordAddr == LAST_ADDR) ? IDLE : READ;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // State, pass timer and word address.
   always_ff @(posedge clk) begin : fsmSeq
      if (rst) begin
         state    <= IDLE;
         timer    <= TIMER_RELOAD;
         wordAddr <= '0;
         active   <= 1'b0;
         done     <= 1'b0;
      end else begin
         state  <= nextState;
         active <= (nextState != IDLE);
         done   <= (nextState == NEXT) && (wordAddr == LAST_ADDR);
         if (state == IDLE) begin
            timer <= (nextState == REQ) ? TIMER_RELOAD : timer - TW'(1);
         end
         if (state == IDLE && nextState == REQ) begin
            wordAddr <= '0;
         end else if (state == NEXT && nextState == READ) begin
            wordAddr <= wordAddr + AW'(1);
         end
      end
   end

   // Read capture and voted write-back data.
   always_ff @(posedge clk) begin : dataSeq
      if (rst) begin
         capA     <= '0;
         capB     <= '0;
         capC     <= '0;
         wdataReg <= '0;
      end else begin
         if (state == WAIT) begin
            capA <= bank.rdataA;
            capB <= bank.rdataB;
            capC <= bank.rdataC;
         end
         if (state == VOTE) wdataReg <= vote;
      end
   end

   // Error reporting; a clear wins over a same-cycle increment but leaves err_lane alone.
   always_ff @(posedge clk) begin : errSeq
      if (rst) begin
         err_lane <= '0;
         err_flag <= 1'b0;
         err_cnt  <= '0;
      end else begin
         if (state == VOTE && mismatch) err_lane <= laneMis;
         if (err_clr) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
         end else if (state == VOTE && mismatch) begin
            err_flag <= 1'b1;
            if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNTW'(1);
         end
      end
   end

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Directed bench for tmr_scrub_ctrl: a default-parameter instance for pass timing,
// correction, stalls, clear and reset abort; a short-interval, 2-bit-counter instance.
module tb_tmr_scrub_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst, rst2, scrubReq, scrubReq2, errClr, errClr2, gnt0;
   logic        busy0, done0, errFlag0, busy1, done1, errFlag1;
   logic [2:0]  errLane0, errLane1;
   logic [15:0] errCnt0;
   logic [1:0]  errCnt1;

   tmr_scrub_if #(.AW(4), .DW(8)) b0 ();
   tmr_scrub_if #(.AW(4), .DW(8)) b1 ();

   assign b0.bank_gnt = gnt0;
   assign b1.bank_gnt = 1'b1;

   tmr_scrub_ctrl #(.NREGS(16), .AW(4), .DW(8), .INTERVAL(1024), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .scrub_req(scrubReq), .bank(b0), .busy(busy0), .done(done0),
      .err_lane(errLane0), .err_flag(errFlag0), .err_cnt(errCnt0), .err_clr(errClr)
   );

   tmr_scrub_ctrl #(.NREGS(16), .AW(4), .DW(8), .INTERVAL(20), .CNTW(2)) dut2 (
      .clk(clk), .rst(rst2), .scrub_req(scrubReq2), .bank(b1), .busy(busy1), .done(done1),
      .err_lane(errLane1), .err_flag(errFlag1), .err_cnt(errCnt1), .err_clr(errClr2)
   );

   // Bank models: one-cycle read latency, writes update all three copies.
   logic [7:0] mem0 [3][16];
   logic [7:0] mem1 [3][16];
   logic       fillReq, plantReq, plantInst;
   logic [3:0] plantAddr;
   logic [7:0] plantA, plantB, plantC;

   function automatic logic [7:0] fillVal(input int w);
      return 8'(w * 37 + 5);
   endfunction

   always @(posedge clk) begin
      if (b0.rd_en) begin
         b0.rdataA <= mem0[0][b0.addr];
         b0.rdataB <= mem0[1][b0.addr];
         b0.rdataC <= mem0[2][b0.addr];
      end
      if (b0.wr_en) for (int l = 0; l < 3; l++) mem0[2'(l)][b0.addr] <= b0.wdata;
      if (fillReq)
         for (int w = 0; w < 16; w++)
            for (int l = 0; l < 3; l++) mem0[2'(l)][4'(w)] <= fillVal(w);
      if (plantReq && !plantInst) begin
         mem0[0][plantAddr] <= plantA;
         mem0[1][plantAddr] <= plantB;
         mem0[2][plantAddr] <= plantC;
      end
   end

   always @(posedge clk) begin
      if (b1.rd_en) begin
         b1.rdataA <= mem1[0][b1.addr];
         b1.rdataB <= mem1[1][b1.addr];
         b1.rdataC <= mem1[2][b1.addr];
      end
      if (b1.wr_en) for (int l = 0; l < 3; l++) mem1[2'(l)][b1.addr] <= b1.wdata;
      if (fillReq)
         for (int w = 0; w < 16; w++)
            for (int l = 0; l < 3; l++) mem1[2'(l)][4'(w)] <= fillVal(w);
      if (plantReq && plantInst) begin
         mem1[0][plantAddr] <= plantA;
         mem1[1][plantAddr] <= plantB;
         mem1[2][plantAddr] <= plantC;
      end
   end

   // Free-running observation of the short-interval instance.
   int rise2Cyc = -1;
   int wr2Cnt   = 0;
   always @(negedge clk) begin
      if (b1.bank_req && rise2Cyc < 0) rise2Cyc <= cyc;
      if (b1.wr_en) wr2Cnt <= wr2Cnt + 1;
   end

   int errors = 0;
   int checks = 0;

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic plant(input logic inst, input logic [3:0] a, input logic [7:0] va,
                        input logic [7:0] vb, input logic [7:0] vc);
      plantInst = inst; plantAddr = a; plantA = va; plantB = vb; plantC = vc;
      plantReq  = 1'b1;
      tick();
      plantReq  = 1'b0;
   endtask

   // Per-pass observations, cycle numbers relative to the scrub_req cycle.
   int riseRel, firstRd, rdCnt, wrCnt, badCnt, doneRel, endRel, rd8Rel, rd8Addr, rd1Addr;
   int wrAddr, wrData;
   logic        abReq, abWr, abBusy;
   logic [3:0]  abAddr;
   logic [2:0]  abLane;
   logic [15:0] abCnt;

   task automatic runPass(input int stallAt, input int stallLen, input int clrAt, input int rstAt);
      int t0, rel;
      bit finished;
      riseRel = -1; firstRd = -1; rdCnt = 0; wrCnt = 0; badCnt = 0; doneRel = -1; endRel = -1;
      rd8Rel = -1; rd8Addr = -1; rd1Addr = -1; wrAddr = -1; wrData = -1;
      finished = 1'b0;
      t0 = cyc;
      scrubReq = 1'b1;
      for (int k = 0; k < 200 && !finished; k++) begin
         @(negedge clk);
         rel = cyc - t0;
         if (b0.bank_req && riseRel < 0) riseRel = rel;
         if ((b0.rd_en || b0.wr_en) && !b0.bank_gnt) badCnt++;
         if (b0.rd_en && b0.wr_en) badCnt++;
         if (b0.rd_en) begin
            rdCnt++;
            if (rdCnt == 1) begin firstRd = rel; rd1Addr = int'(b0.addr); end
            if (rdCnt == 8) begin rd8Rel = rel; rd8Addr = int'(b0.addr); end
         end
         if (b0.wr_en) begin wrCnt++; wrAddr = int'(b0.addr); wrData = int'(b0.wdata); end
         if (done0) doneRel = rel;
         if (doneRel >= 0 && !b0.bank_req && endRel < 0) begin endRel = rel; finished = 1'b1; end
         if (rstAt >= 0 && rel == rstAt + 1) begin
            abReq = b0.bank_req; abWr = b0.wr_en; abBusy = busy0; abAddr = b0.addr;
            abCnt = errCnt0; abLane = errLane0;
            finished = 1'b1;
         end
         tick();
         rel      = cyc - t0;
         scrubReq = 1'b0;
         gnt0     = !(rel >= stallAt && rel < stallAt + stallLen);
         errClr   = (rel == clrAt);
         rst      = (rel == rstAt);
      end
      gnt0 = 1'b1; errClr = 1'b0; rst = 1'b0;
      checkEq("pass completed within budget", 32'(finished), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int rBase;
   int upsets[5] = '{1, 3, 5, 7, 9};

   initial begin
      rst = 1'b1; rst2 = 1'b1; scrubReq = 1'b0; scrubReq2 = 1'b0; errClr = 1'b0; errClr2 = 1'b0;
      gnt0 = 1'b1; fillReq = 1'b0; plantReq = 1'b0; plantInst = 1'b0; plantAddr = '0;
      plantA = '0; plantB = '0; plantC = '0;
      repeat (2) tick();
      fillReq = 1'b1;
      tick();
      fillReq = 1'b0;
      foreach (upsets[i]) plant(1'b1, 4'(upsets[i]), fillVal(upsets[i]),
                                fillVal(upsets[i]) ^ 8'h01, fillVal(upsets[i]));

      @(negedge clk);
      checkEq("reset bank_req", 32'(b0.bank_req), 0);
      checkEq("reset rd_en",    32'(b0.rd_en), 0);
      checkEq("reset wr_en",    32'(b0.wr_en), 0);
      checkEq("reset addr",     32'(b0.addr), 0);
      checkEq("reset wdata",    32'(b0.wdata), 0);
      checkEq("reset busy",     32'(busy0), 0);
      checkEq("reset done",     32'(done0), 0);
      checkEq("reset err_lane", 32'(errLane0), 0);
      checkEq("reset err_flag", 32'(errFlag0), 0);
      checkEq("reset err_cnt",  32'(errCnt0), 0);

      tick();
      rst = 1'b0; rst2 = 1'b0;
      rBase = cyc;
      repeat (4) tick();

      // Clean pass.
      runPass(-1, 0, -1, -1);
      checkEq("clean bank_req rise", 32'(riseRel), 1);
      checkEq("clean first rd_en",   32'(firstRd), 2);
      checkEq("clean rd_en count",   32'(rdCnt), 16);
      checkEq("clean wr_en count",   32'(wrCnt), 0);
      checkEq("clean done",          32'(doneRel), 65);
      checkEq("clean bank_req fall", 32'(endRel), 66);
      checkEq("clean strobe rules",  32'(badCnt), 0);
      checkEq("clean err_cnt",       32'(errCnt0), 0);
      checkEq("clean err_flag",      32'(errFlag0), 0);

      // Single upset on lane C.
      plant(1'b0, 4'd5, 8'h3C, 8'h3C, 8'hBC);
      runPass(-1, 0, -1, -1);
      checkEq("upset wr_en count", 32'(wrCnt), 1);
      checkEq("upset wr addr",     32'(wrAddr), 5);
      checkEq("upset wdata",       32'(wrData), 32'h3C);
      checkEq("upset err_lane",    32'(errLane0), 32'h4);
      checkEq("upset err_flag",    32'(errFlag0), 1);
      checkEq("upset err_cnt",     32'(errCnt0), 1);
      checkEq("upset done",        32'(doneRel), 66);
      checkEq("upset rd_en count", 32'(rdCnt), 16);
      checkEq("upset repaired C",  32'(mem0[2][5]), 32'h3C);

      // Bitwise vote across two disagreeing lanes.
      plant(1'b0, 4'd2, 8'h0F, 8'hF0, 8'hFF);
      runPass(-1, 0, -1, -1);
      checkEq("multi wr addr",    32'(wrAddr), 2);
      checkEq("multi wdata",      32'(wrData), 32'hFF);
      checkEq("multi err_lane",   32'(errLane0), 32'h3);
      checkEq("multi err_cnt",    32'(errCnt0), 2);
      checkEq("multi repaired A", 32'(mem0[0][2]), 32'hFF);

      // Grant dropped for three cycles during the read of word 7.
      runPass(30, 3, -1, -1);
      checkEq("stall word7 read cycle", 32'(rd8Rel), 33);
      checkEq("stall word7 read addr",  32'(rd8Addr), 7);
      checkEq("stall done",             32'(doneRel), 68);
      checkEq("stall strobe rules",     32'(badCnt), 0);
      checkEq("stall wr_en count",      32'(wrCnt), 0);
      checkEq("stall err_cnt",          32'(errCnt0), 2);

      // Clear coinciding with a mismatch in VOTE of word 0.
      plant(1'b0, 4'd0, 8'h00, 8'h01, 8'h01);
      runPass(-1, 0, 4, -1);
      checkEq("clr err_cnt",   32'(errCnt0), 0);
      checkEq("clr err_flag",  32'(errFlag0), 0);
      checkEq("clr err_lane",  32'(errLane0), 32'h1);
      checkEq("clr wdata",     32'(wrData), 32'h01);

      // Reset while writing back word 3.
      plant(1'b0, 4'd3, 8'h55, 8'h55, 8'h54);
      runPass(-1, 0, -1, 17);
      checkEq("abort saw write",  32'(wrCnt), 1);
      checkEq("abort bank_req",   32'(abReq), 0);
      checkEq("abort wr_en",      32'(abWr), 0);
      checkEq("abort busy",       32'(abBusy), 0);
      checkEq("abort addr",       32'(abAddr), 0);
      checkEq("abort err_cnt",    32'(abCnt), 0);
      checkEq("abort err_lane",   32'(abLane), 0);

      tick();
      runPass(-1, 0, -1, -1);
      checkEq("restart first addr", 32'(rd1Addr), 0);
      checkEq("restart first rd",   32'(firstRd), 2);
      checkEq("restart done",       32'(doneRel), 65);

      // Short-interval instance: automatic start and saturating counter.
      checkEq("auto pass start",   32'(rise2Cyc - rBase), 20);
      checkEq("sat err_cnt",       32'(errCnt1), 3);
      checkEq("sat err_flag",      32'(errFlag1), 1);
      checkEq("sat err_lane",      32'(errLane1), 32'h2);
      checkEq("sat write count",   32'(wr2Cnt), 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tmr_scrub_ctrl.md
# tmr_scrub_ctrl

Scrubbing controller for triplicated register banks. Periodically, or on request, it walks every word of a TMR register bank and reads the A/B/C copies. It bitwise-votes them and writes the voted value back to all three copies when any copy disagrees. It sits beside the bank and shares the bank port with user logic through a req/gnt handshake. It reports per-lane mismatches and a saturating error count.

## Interface
Parameters:
- NREGS, 16, number of words in the bank (≥2)
- AW, 4, address width (2^AW ≥ NREGS)
- DW, 8, data width per copy
- INTERVAL, 1024, idle cycles between automatic passes (≥2)
- CNTW, 16, error counter width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- scrub_req  in  1  start a pass now; sampled only in IDLE
- bank_req  out  1  controller requests the bank port
- bank_gnt  in  1  bank port granted; may drop at any time
- addr  out  AW  word address
- rd_en  out  1  read strobe; rdataA/B/C valid the following cycle
- rdataA / rdataB / rdataC  in  DW  the three copies of the word
- wr_en  out  1  write voted data to all three copies at addr
- wdata  out  DW  voted word
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse on the last word of a pass
- err_lane  out  3  lanes that disagreed at the last mismatch (bit0=A, bit1=B, bit2=C)
- err_flag  out  1  sticky, set on any mismatch
- err_cnt  out  CNTW  count of mismatching words, saturating
- err_clr  in  1  clears err_cnt and err_flag

## Operation
- Bitwise majority: vote = (A&B)|(B&C)|(A&C).
- A word mismatches if any copy differs from vote. Lane bit i = (copy_i != vote).
- FSM states: IDLE, REQ, READ, WAIT, VOTE, WRITE, NEXT.
- IDLE:
  - Timer decrements each cycle.
  - Go to REQ when timer==0 or scrub_req=1.
  - On leaving IDLE: addr=0 and timer reloads INTERVAL-1.
  - The timer holds outside IDLE.
- REQ: go to READ when bank_gnt=1.
- READ: rd_en=bank_gnt. Stall while bank_gnt=0. Go to WAIT after the strobe is issued.
- WAIT: capture rdataA/B/C into internal registers. Go to VOTE.
- VOTE: compute vote and mismatch. Go to WRITE on mismatch, else NEXT.
  - On mismatch: err_lane updates, err_flag sets, and err_cnt increments (saturating at 2^CNTW-1).
- WRITE: wr_en=bank_gnt, wdata=vote. Stall while bank_gnt=0. Go to NEXT after the write is issued.
- NEXT:
  - If addr==NREGS-1: done=1, go to IDLE.
  - Otherwise addr+1, go to READ.
- bank_req=busy=(state!=IDLE). bank_req stays high for the whole pass.
- rd_en and wr_en are never asserted together, and never when bank_gnt=0.
- wdata holds the last voted value; it is meaningful only with wr_en.
- scrub_req during a pass is ignored, not queued.
- err_clr has priority over a same-cycle increment: the result is err_cnt=0, err_flag=0.
- err_lane is not cleared by err_clr.
- Reset mid-pass aborts the pass immediately; no partial write is issued after the reset cycle.

## Timing
- Reset values: bank_req=0, rd_en=0, wr_en=0, addr=0, wdata=0, busy=0, done=0, err_lane=0, err_flag=0, err_cnt=0, state IDLE, timer=INTERVAL-1.
- scrub_req high in IDLE at cycle t gives bank_req=1 at t+1.
- With bank_gnt held high:
  - rd_en for word 0 at t+2.
  - Each clean word takes 4 cycles (READ, WAIT, VOTE, NEXT); a corrected word takes 5.
  - A clean 16-word pass has done at t+65 and bank_req=0 at t+66.
- Automatic pass: bank_req rises INTERVAL cycles after the first IDLE cycle.
- Error outputs update in the cycle after VOTE.
- Grant loss adds one cycle per stalled cycle in READ/WRITE. Grant loss in WAIT/VOTE/NEXT has no effect.

## Test plan
- Clean pass: reset, bank_gnt=1, all copies equal, scrub_req pulse at cycle 10 -> bank_req at 11; 16 rd_en pulses, first at 12; no wr_en; done at 75; err_cnt=0.
- Single upset: word 5 with A=8'h3C, B=8'h3C, C=8'hBC -> one wr_en at addr=5 with wdata=8'h3C; err_lane=3'b100; err_flag=1; err_cnt=1; done 1 cycle later than the clean pass.
- Multi-lane bitwise: A=8'h0F, B=8'hF0, C=8'hFF at addr 2 -> wdata=8'hFF, err_lane=3'b011.
- Grant stall: drop bank_gnt for 3 cycles while in READ of word 7 -> no rd_en during the stall; read at addr 7 once the grant returns; done delayed exactly 3 cycles.
- Timer and saturation:
  - INTERVAL=20: automatic pass starts 20 cycles after the reset-release IDLE.
  - CNTW=2 with 5 corrupted words: err_cnt stops at 3.
  - err_clr asserted during a VOTE mismatch: err_cnt=0.
- Reset mid-pass: assert rst during WRITE -> next cycle bank_req=0, wr_en=0, err_cnt=0, addr=0; following scrub_req restarts at addr 0.
